// File: rtl/matrix_hps_bridge_if.sv
// HPS command/readback channel and coprocessor control lines grouped as one bus.
// The slave modport is the bridge's view; the master modport is the HPS/coprocessor side.
interface matrix_hps_bridge_if;
  logic         cmd_valid;
  logic [31:0]  cmd_data;
  logic         cmd_ready;
  logic         rd_req;
  logic [31:0]  rd_data;
  logic         rd_valid;
  logic         busy;
  logic         done;
  logic         ovf;
  logic         err;
  logic [199:0] cp_matrix1;
  logic [199:0] cp_matrix2;
  logic [4:0]   cp_instruction;
  logic         cp_start;
  logic         cp_ready;
  logic [199:0] cp_result;
  logic         cp_overflow;

  modport slave (
    input  cmd_valid, cmd_data, rd_req, cp_ready, cp_result, cp_overflow,
    output cmd_ready, rd_data, rd_valid, busy, done, ovf, err,
           cp_matrix1, cp_matrix2, cp_instruction, cp_start
  );

  modport master (
    output cmd_valid, cmd_data, rd_req, cp_ready, cp_result, cp_overflow,
    input  cmd_ready, rd_data, rd_valid, busy, done, ovf, err,
           cp_matrix1, cp_matrix2, cp_instruction, cp_start
  );
endinterface

// File: rtl/matrix_hps_bridge.sv
// Bridge between the HPS 32-bit command/readback channel and the matrix coprocessor.
// Loads a header plus two 5x5 byte matrices, runs the start/ready handshake with a
// timeout, captures the 200-bit result and streams it back as 32-bit words.
module matrix_hps_bridge #(
  parameter int WAIT_LIMIT = 4096
) (
  input  logic               clk,
  input  logic               rst,
  matrix_hps_bridge_if.slave bus
);

  localparam int              CNT_W    = $clog2(WAIT_LIMIT) + 1;
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(WAIT_LIMIT - 1);
  localparam logic [CNT_W-1:0] TMO_ONE  = CNT_W'(1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD_A  = 3'd1;
  localparam logic [2:0] S_LOAD_B  = 3'd2;
  localparam logic [2:0] S_ISSUE   = 3'd3;
  localparam logic [2:0] S_WAIT    = 3'd4;
  localparam logic [2:0] S_CAPTURE = 3'd5;
  localparam logic [2:0] S_READOUT = 3'd6;

  logic [2:0]       state_q,   state_d;
  logic [2:0]       ptr_q,     ptr_d;
  logic [2:0]       rd_ptr_q,  rd_ptr_d;
  logic [4:0]       instr_q,   instr_d;
  logic [199:0]     m1_q,      m1_d;
  logic [199:0]     m2_q,      m2_d;
  logic [199:0]     res_q,     res_d;
  logic [CNT_W-1:0] tmo_q,     tmo_d;
  logic [31:0]      rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d;
  logic             done_q,    done_d;
  logic             ovf_q,     ovf_d;
  logic             err_q,     err_d;
  logic             cmd_ready_c;
  logic             cmd_fire;
  logic             take_header;

  // Word j of a matrix holds elements 4j..4j+3; word 6 only carries element 24 in its top byte.
  function automatic logic [199:0] put_word(input logic [199:0] m, input logic [2:0] ptr,
                                            input logic [31:0] w);
    logic [199:0] r;
    r = m;
    for (int j = 0; j < 6; j++) begin
      if (ptr == 3'(j)) r[199-32*j -: 32] = w;
    end
    if (ptr == 3'd6) r[7:0] = w[31:24];
    return r;
  endfunction

  // Inverse of put_word; the unused bytes of word 6 read back as zero.
  function automatic logic [31:0] get_word(input logic [199:0] m, input logic [2:0] ptr);
    logic [31:0] r;
    r = 32'h0;
    for (int j = 0; j < 6; j++) begin
      if (ptr == 3'(j)) r = m[199-32*j -: 32];
    end
    if (ptr == 3'd6) r = {m[7:0], 24'h0};
    return r;
  endfunction

  assign cmd_ready_c = (state_q == S_IDLE) || (state_q == S_LOAD_A) ||
                       (state_q == S_LOAD_B) || (state_q == S_READOUT);
  assign cmd_fire    = bus.cmd_valid && cmd_ready_c;

  // Next-state and datapath update for load, handshake, capture and readout.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    rd_ptr_d    = rd_ptr_q;
    instr_d     = instr_q;
    m1_d        = m1_q;
    m2_d        = m2_q;
    res_d       = res_q;
    tmo_d       = tmo_q;
    rd_data_d   = rd_data_q;
    rd_valid_d  = 1'b0;
    done_d      = done_q;
    ovf_d       = ovf_q;
    err_d       = err_q;
    take_header = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cmd_fire) take_header = 1'b1;
      end
      S_LOAD_A: begin
        if (cmd_fire) begin
          m1_d = put_word(m1_q, ptr_q, bus.cmd_data);
          if (ptr_q == 3'd6) begin
            ptr_d   = 3'd0;
            state_d = S_LOAD_B;
          end else begin
            ptr_d = ptr_q + 3'd1;
          end
        end
      end
      S_LOAD_B: begin
        if (cmd_fire) begin
          m2_d = put_word(m2_q, ptr_q, bus.cmd_data);
          if (ptr_q == 3'd6) begin
            ptr_d   = 3'd0;
            tmo_d   = '0;
            state_d = S_ISSUE;
          end else begin
            ptr_d = ptr_q + 3'd1;
          end
        end
      end
      S_ISSUE: begin
        if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          done_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q + TMO_ONE;
          if (!bus.cp_ready) state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // Completion on the final allowed cycle still counts as success.
        if (bus.cp_ready) begin
          state_d = S_CAPTURE;
        end else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          done_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q + TMO_ONE;
        end
      end
      S_CAPTURE: begin
        res_d    = bus.cp_result;
        ovf_d    = bus.cp_overflow;
        done_d   = 1'b1;
        rd_ptr_d = 3'd0;
        state_d  = S_READOUT;
      end
      S_READOUT: begin
        // A new header wins over a read request in the same cycle.
        if (cmd_fire) begin
          take_header = 1'b1;
        end else if (bus.rd_req) begin
          rd_data_d  = get_word(res_q, rd_ptr_q);
          rd_valid_d = 1'b1;
          rd_ptr_d   = (rd_ptr_q == 3'd6) ? 3'd0 : rd_ptr_q + 3'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (take_header) begin
      instr_d  = bus.cmd_data[4:0];
      done_d   = 1'b0;
      ovf_d    = 1'b0;
      err_d    = 1'b0;
      ptr_d    = 3'd0;
      rd_ptr_d = 3'd0;
      state_d  = S_LOAD_A;
    end
  end

  // State and data registers; reset aborts any operation and clears everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      rd_ptr_q   <= '0;
      instr_q    <= '0;
      m1_q       <= '0;
      m2_q       <= '0;
      res_q      <= '0;
      tmo_q      <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      instr_q    <= instr_d;
      m1_q       <= m1_d;
      m2_q       <= m2_d;
      res_q      <= res_d;
      tmo_q      <= tmo_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      done_q     <= done_d;
      ovf_q      <= ovf_d;
      err_q      <= err_d;
    end
  end

  assign bus.cmd_ready      = cmd_ready_c;
  assign bus.rd_data        = rd_data_q;
  assign bus.rd_valid       = rd_valid_q;
  assign bus.busy           = (state_q == S_ISSUE) || (state_q == S_WAIT) || (state_q == S_CAPTURE);
  assign bus.done           = done_q;
  assign bus.ovf            = ovf_q;
  assign bus.err            = err_q;
  assign bus.cp_matrix1     = m1_q;
  assign bus.cp_matrix2     = m2_q;
  assign bus.cp_instruction = instr_q;
  assign bus.cp_start       = (state_q == S_ISSUE);

endmodule

// File: tb/tb_matrix_hps_bridge.sv
// Directed bench for matrix_hps_bridge: a main instance with the default timeout
// and a second instance with WAIT_LIMIT=16 sharing the HPS-side stimulus.
module tb_matrix_hps_bridge;

  typedef logic [7:0] mat_t [25];

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cpr_t = 1'b0;
  int   n_assert = 0;
  int   n_fail   = 0;
  logic [31:0] exp_q [$];
  mat_t ea, eb, er;
  logic held;

  always #5 clk = ~clk;

  matrix_hps_bridge_if b ();
  matrix_hps_bridge_if bt ();

  assign bt.cmd_valid   = b.cmd_valid;
  assign bt.cmd_data    = b.cmd_data;
  assign bt.rd_req      = b.rd_req;
  assign bt.cp_ready    = cpr_t;
  assign bt.cp_result   = b.cp_result;
  assign bt.cp_overflow = b.cp_overflow;

  matrix_hps_bridge #(.WAIT_LIMIT(4096)) dut   (.clk(clk), .rst(rst), .bus(b));
  matrix_hps_bridge #(.WAIT_LIMIT(16))   dut_t (.clk(clk), .rst(rst), .bus(bt));

  task automatic check(input string tag, input logic [199:0] got, input logic [199:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [199:0] pack(input mat_t e);
    logic [199:0] r;
    r = '0;
    for (int k = 0; k < 25; k++) r = {r[191:0], e[k]};
    return r;
  endfunction

  function automatic logic [31:0] word_of(input mat_t e, input int j);
    logic [31:0] w;
    w = 32'h0;
    for (int k = 4*j; k < 4*j + 4; k++) w = (w << 8) | ((k < 25) ? {24'h0, e[k]} : 32'h0);
    return w;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] w);
    b.cmd_valid = 1'b1;
    b.cmd_data  = w;
    step();
    b.cmd_valid = 1'b0;
  endtask

  // Header plus both matrices at full rate; word 6 carries junk in its unused bytes.
  task automatic load_all(input logic [31:0] hdr);
    send(hdr);
    for (int j = 0; j < 7; j++) send(word_of(ea, j) | ((j == 6) ? 32'h00A5C35A : 32'h0));
    for (int j = 0; j < 7; j++) send(word_of(eb, j) | ((j == 6) ? 32'h005AC3A5 : 32'h0));
  endtask

  task automatic check_reset(input string ph);
    check({ph, "_rd_data"},    b.rd_data, 0);
    check({ph, "_rd_valid"},   b.rd_valid, 0);
    check({ph, "_busy"},       b.busy, 0);
    check({ph, "_done"},       b.done, 0);
    check({ph, "_ovf"},        b.ovf, 0);
    check({ph, "_err"},        b.err, 0);
    check({ph, "_m1"},         b.cp_matrix1, 0);
    check({ph, "_m2"},         b.cp_matrix2, 0);
    check({ph, "_instr"},      b.cp_instruction, 0);
    check({ph, "_cp_start"},   b.cp_start, 0);
    check({ph, "_cmd_ready"},  b.cmd_ready, 1);
  endtask

  // Scoreboard: every rd_valid pops the oldest expected word.
  always @(negedge clk) begin
    if (b.rd_valid) begin
      if (exp_q.size() == 0) check("rd_spurious", b.rd_valid, 0);
      else check("rd_word", b.rd_data, exp_q.pop_front());
    end
  end

  initial begin
    b.cmd_valid = 1'b0; b.cmd_data = 32'h0; b.rd_req = 1'b0;
    b.cp_ready = 1'b1; b.cp_result = '0; b.cp_overflow = 1'b0;
    step(); step();
    rst = 1'b0;
    check_reset("por");

    // Normal add with handshake-order and timeout observation
    for (int k = 0; k < 25; k++) begin ea[k] = 8'h01; eb[k] = 8'h02; er[k] = 8'h03; end
    load_all(32'h0000_0003);
    check("issue_cp_start", b.cp_start, 1);
    check("issue_busy", b.busy, 1);
    check("issue_cmd_ready", b.cmd_ready, 0);
    check("issue_instr", b.cp_instruction, 5'h03);
    check("issue_m1", b.cp_matrix1, pack(ea));
    check("issue_m2", b.cp_matrix2, pack(eb));
    check("t_issue_start", bt.cp_start, 1);
    held = 1'b1;
    for (int i = 0; i < 15; i++) begin step(); held = held & b.cp_start & b.busy; end
    check("t_err_before", bt.err, 0);
    step(); held = held & b.cp_start & b.busy;
    check("t_err", bt.err, 1);
    check("t_done", bt.done, 0);
    check("t_cp_start", bt.cp_start, 0);
    check("t_busy", bt.busy, 0);
    check("t_cmd_ready", bt.cmd_ready, 1);
    for (int i = 0; i < 4; i++) begin step(); held = held & b.cp_start & b.busy; end
    check("start_held", held, 1);
    b.cp_ready = 1'b0;
    step();
    check("wait_cp_start", b.cp_start, 0);
    check("wait_busy", b.busy, 1);
    step(); step(); step();
    b.cp_result = pack(er); b.cp_overflow = 1'b0; b.cp_ready = 1'b1;
    cpr_t = 1'b1;
    step();
    check("capture_busy", b.busy, 1);
    check("capture_done", b.done, 0);
    step();
    check("readout_done", b.done, 1);
    check("readout_busy", b.busy, 0);
    check("readout_ovf", b.ovf, 0);
    check("readout_cmd_ready", b.cmd_ready, 1);

    // Nine back-to-back reads wrap to words 0 and 1
    for (int i = 0; i < 9; i++) begin
      exp_q.push_back(word_of(er, i % 7));
      b.rd_req = 1'b1;
      step();
    end
    b.rd_req = 1'b0;
    step(); step();
    check("rd_queue_empty", exp_q.size(), 0);
    check("t_late_ready_done", bt.done, 0);
    check("t_late_ready_busy", bt.busy, 0);

    // Header and rd_req together: header wins
    b.cmd_valid = 1'b1; b.cmd_data = 32'h0000_0003; b.rd_req = 1'b1;
    step();
    b.cmd_valid = 1'b0; b.rd_req = 1'b0;
    check("prio_rd_valid", b.rd_valid, 0);
    check("prio_done", b.done, 0);
    check("t_hdr_clears_err", bt.err, 0);
    b.rd_req = 1'b1;
    step();
    b.rd_req = 1'b0;
    check("load_rd_ignored", b.rd_valid, 0);
    send(32'hAABB_CCDD);
    check("prio_load_a_word0", b.cp_matrix1[199:168], 32'hAABB_CCDD);
    send(32'h1122_3344);
    send(32'h5566_7788);

    // Reset after three A words
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_reset("midrst");

    // Full transaction returning overflow
    for (int k = 0; k < 25; k++) begin
      ea[k] = 8'($urandom_range(0, 255));
      eb[k] = 8'($urandom_range(0, 255));
      er[k] = 8'h7F;
    end
    load_all(32'hFFFF_FF0A);
    check("ovf_instr", b.cp_instruction, 5'h0A);
    check("ovf_m1", b.cp_matrix1, pack(ea));
    check("ovf_m2", b.cp_matrix2, pack(eb));
    b.cp_ready = 1'b0;
    step(); step(); step();
    b.cp_result = pack(er); b.cp_overflow = 1'b1; b.cp_ready = 1'b1;
    step(); step();
    b.cp_overflow = 1'b0;
    check("ovf_flag", b.ovf, 1);
    check("ovf_done", b.done, 1);
    for (int i = 0; i < 7; i++) begin
      exp_q.push_back(word_of(er, i));
      b.rd_req = 1'b1;
      step();
    end
    b.rd_req = 1'b0;
    step(); step();
    check("ovf_rd_queue_empty", exp_q.size(), 0);
    send(32'h0000_0003);
    check("ovf_cleared", b.ovf, 0);
    check("ovf_hdr_done", b.done, 0);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
